// File: rtl/ascon_sbox_lut_pipe.sv
// ascon_sbox_lut_pipe: programmable S-box lookup engine for the Ascon
// substitution layer. A full slice-address vector is accepted in one cycle.
// It is resolved LANES_PER_CYCLE slices per cycle against a writable table.
// The result vector is then held until the consumer takes it.
module ascon_sbox_lut_pipe #(
    parameter int SBOX_W          = 5,
    parameter int N_SLICES        = 64,
    parameter int LANES_PER_CYCLE = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cfg_we_i,
    input  logic [SBOX_W-1:0]            cfg_addr_i,
    input  logic [SBOX_W-1:0]            cfg_wdata_i,
    output logic                         cfg_ready_o,
    output logic [SBOX_W-1:0]            cfg_rdata_o,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [N_SLICES*SBOX_W-1:0]   addr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [N_SLICES*SBOX_W-1:0]   data_o
);

    localparam int NUM_CHUNKS = N_SLICES / LANES_PER_CYCLE;
    localparam int TBL_N      = 1 << SBOX_W;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int VEC_W      = N_SLICES * SBOX_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Power-on table contents: the Ascon S-box for 5-bit tables, identity otherwise.
    function automatic logic [SBOX_W-1:0] sbox_default(input int idx);
        logic [4:0] v;
        case (idx[4:0])
            5'd0:    v = 5'h04;
            5'd1:    v = 5'h0B;
            5'd2:    v = 5'h1F;
            5'd3:    v = 5'h14;
            5'd4:    v = 5'h1A;
            5'd5:    v = 5'h15;
            5'd6:    v = 5'h09;
            5'd7:    v = 5'h02;
            5'd8:    v = 5'h1B;
            5'd9:    v = 5'h05;
            5'd10:   v = 5'h08;
            5'd11:   v = 5'h12;
            5'd12:   v = 5'h1D;
            5'd13:   v = 5'h03;
            5'd14:   v = 5'h06;
            5'd15:   v = 5'h1C;
            5'd16:   v = 5'h1E;
            5'd17:   v = 5'h13;
            5'd18:   v = 5'h07;
            5'd19:   v = 5'h0E;
            5'd20:   v = 5'h00;
            5'd21:   v = 5'h0D;
            5'd22:   v = 5'h11;
            5'd23:   v = 5'h18;
            5'd24:   v = 5'h10;
            5'd25:   v = 5'h0C;
            5'd26:   v = 5'h01;
            5'd27:   v = 5'h19;
            5'd28:   v = 5'h16;
            5'd29:   v = 5'h0A;
            5'd30:   v = 5'h0F;
            5'd31:   v = 5'h17;
            default: v = 5'h00;
        endcase
        if (SBOX_W == 5) begin
            return SBOX_W'(v);
        end else begin
            return SBOX_W'(idx);
        end
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [VEC_W-1:0]    r_addr;
    logic [VEC_W-1:0]    r_data;
    logic [VEC_W-1:0]    w_data_nxt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [SBOX_W-1:0]   r_table [TBL_N];
    logic                w_accept;
    logic                w_cfg_wr;

    // Request acceptance and config writes are both gated by the IDLE-only ready flag.
    assign w_accept = in_valid_i & r_in_ready;
    assign w_cfg_wr = cfg_we_i & r_in_ready;

    assign in_ready_o  = r_in_ready;
    assign cfg_ready_o = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign data_o      = r_data;
    assign cfg_rdata_o = r_table[cfg_addr_i];

    // Next-state decode for the IDLE -> RUN -> DONE sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid_i) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Chunk counter: cleared on accept, steps through the chunks while running.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Address capture: addr_i only has to be valid in the accept cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= addr_i;
        end else begin
            r_addr <= r_addr;
        end
    end

    // Result merge: the current chunk's slices are replaced, all others hold.
    always_comb begin
        w_data_nxt = r_data;
        if (r_state == ST_RUN) begin
            for (int l = 0; l < LANES_PER_CYCLE; l++) begin
                w_data_nxt[(int'(r_cnt) * LANES_PER_CYCLE + l) * SBOX_W +: SBOX_W] =
                    r_table[r_addr[(int'(r_cnt) * LANES_PER_CYCLE + l) * SBOX_W +: SBOX_W]];
            end
        end else begin
            w_data_nxt = r_data;
        end
    end

    // Result register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data <= '0;
        end else begin
            r_data <= w_data_nxt;
        end
    end

    // Substitution table: reverts to defaults on reset, writable only in IDLE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < TBL_N; i++) begin
                r_table[i] <= sbox_default(i);
            end
        end else if (w_cfg_wr) begin
            r_table[cfg_addr_i] <= cfg_wdata_i;
        end else begin
            r_table <= r_table;
        end
    end

endmodule

// File: tb/tb_ascon_sbox_lut_pipe.sv
// Self-checking bench for ascon_sbox_lut_pipe: directed steps, scoreboard queue
// of expected result vectors, immediate assertions at every comparison point.
module tb_ascon_sbox_lut_pipe;

    localparam int W   = 5;
    localparam int NS  = 64;
    localparam int LPC = 16;
    localparam int NCH = NS / LPC;
    localparam int VW  = NS * W;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          cfg_we_i;
    logic [W-1:0]  cfg_addr_i;
    logic [W-1:0]  cfg_wdata_i;
    logic          cfg_ready_o;
    logic [W-1:0]  cfg_rdata_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [VW-1:0] addr_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [VW-1:0] data_o;

    ascon_sbox_lut_pipe #(.SBOX_W(W), .N_SLICES(NS), .LANES_PER_CYCLE(LPC)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_ready_o(cfg_ready_o), .cfg_rdata_o(cfg_rdata_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .addr_i(addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int            total = 0;
    int            bad   = 0;
    logic [W-1:0]  ascon_def [32];
    logic [W-1:0]  ref_tbl   [32];
    logic [VW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [VW-1:0] model(input logic [VW-1:0] a);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++) r[i*W +: W] = ref_tbl[a[i*W +: W]];
        return r;
    endfunction

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid_o && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("out_valid_timeout", {{(VW-1){1'b0}}, out_valid_o}, {{(VW-1){1'b0}}, 1'b1});
    endtask

    task automatic take_result(input string tag);
        logic [VW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, data_o, e);
        end
    endtask

    task automatic issue(input logic [VW-1:0] a);
        addr_i     = a;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        exp_q.push_back(model(a));
    endtask

    initial begin
        int cyc;
        logic [VW-1:0] a;
        logic [VW-1:0] held;
        ascon_def = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                      5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                      5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                      5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
        ref_tbl = ascon_def;
        rst_n_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        in_valid_i = 1'b0; addr_i = '0; out_ready_i = 1'b1;

        // Step 1: reset values and table read-back.
        tick(); tick();
        chk("rst_out_valid", VW'(out_valid_o), VW'(1'b0));
        chk("rst_data", data_o, '0);
        chk("rst_in_ready", VW'(in_ready_o), VW'(1'b1));
        chk("rst_cfg_ready", VW'(cfg_ready_o), VW'(1'b1));
        rst_n_i = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            cfg_addr_i = W'(i);
            #1;
            chk("rst_table", VW'(cfg_rdata_o), VW'(ascon_def[i]));
        end

        // Step 2: default lookup, latency and spot values.
        for (int i = 0; i < NS; i++) a[i*W +: W] = W'(i % 32);
        issue(a);
        chk("run_in_ready", VW'(in_ready_o), VW'(1'b0));
        wait_valid(cyc);
        chk("latency", VW'(cyc), VW'(NCH));
        chk("slice0", VW'(data_o[0 +: W]), VW'(5'h04));
        chk("slice2", VW'(data_o[2*W +: W]), VW'(5'h1F));
        chk("slice63", VW'(data_o[63*W +: W]), VW'(5'h17));
        take_result("default_lookup");
        tick();
        chk("idle_after_done", VW'(in_ready_o), VW'(1'b1));

        // Step 3: same-edge reprogram and lookup; lookup sees the new entry.
        cfg_we_i = 1'b1; cfg_addr_i = '0; cfg_wdata_i = 5'h1F;
        ref_tbl[0] = 5'h1F;
        issue('0);
        cfg_we_i = 1'b0;
        chk("wr_readback", VW'(cfg_rdata_o), VW'(5'h1F));
        wait_valid(cyc);
        take_result("reprog_lookup");
        tick();

        // Step 4: backpressure in DONE with a pending request.
        out_ready_i = 1'b0;
        for (int i = 0; i < NS; i++) a[i*W +: W] = W'($urandom_range(31, 0));
        issue(a);
        wait_valid(cyc);
        held = data_o;
        for (int i = 0; i < NS; i++) addr_i[i*W +: W] = W'($urandom_range(31, 0));
        in_valid_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_valid", VW'(out_valid_o), VW'(1'b1));
            chk("bp_data_stable", data_o, held);
            chk("bp_in_ready", VW'(in_ready_o), VW'(1'b0));
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        take_result("backpressure");
        tick();
        chk("bp_release_ready", VW'(in_ready_o), VW'(1'b1));
        chk("bp_release_valid", VW'(out_valid_o), VW'(1'b0));

        // Step 5: config write attempted during RUN is dropped.
        for (int i = 0; i < NS; i++) a[i*W +: W] = W'(3);
        issue(a);
        cfg_we_i = 1'b1; cfg_addr_i = W'(3); cfg_wdata_i = 5'h00;
        #1;
        chk("blk_cfg_ready", VW'(cfg_ready_o), VW'(1'b0));
        wait_valid(cyc);
        cfg_we_i = 1'b0;
        chk("blk_entry3", VW'(cfg_rdata_o), VW'(5'h14));
        take_result("cfg_blocked");
        tick();
        chk("blk_entry3_after", VW'(cfg_rdata_o), VW'(5'h14));

        // Step 6: reset in the second RUN cycle aborts and reverts the table.
        cfg_we_i = 1'b1; cfg_addr_i = W'(5); cfg_wdata_i = 5'h00;
        tick();
        cfg_we_i = 1'b0;
        chk("prog_entry5", VW'(cfg_rdata_o), VW'(5'h00));
        for (int i = 0; i < NS; i++) a[i*W +: W] = W'(5);
        addr_i = a; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        rst_n_i = 1'b0;
        #1;
        chk("midrst_in_ready", VW'(in_ready_o), VW'(1'b1));
        chk("midrst_valid", VW'(out_valid_o), VW'(1'b0));
        tick();
        rst_n_i = 1'b1;
        ref_tbl = ascon_def;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid_o) cyc++;
        end
        chk("midrst_no_result", VW'(cyc), VW'(0));
        chk("midrst_idle", VW'(in_ready_o), VW'(1'b1));
        chk("midrst_entry5", VW'(cfg_rdata_o), VW'(5'h15));

        // Step 7: back-to-back random lookups after the abort.
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NS; i++) a[i*W +: W] = W'($urandom_range(31, 0));
            issue(a);
            wait_valid(cyc);
            chk("rand_latency", VW'(cyc), VW'(NCH));
            take_result("rand_lookup");
            tick();
        end
        chk("scoreboard_drained", VW'(exp_q.size()), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
